// File: rtl/booth_pkg.sv
// Shared types for the Booth result collector: FSM states and result-bus selector tags.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LO_HELD = 2'd1,
        HI_HELD = 2'd2
    } collect_state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_X    = 2'b01;
    localparam logic [1:0] SEL_A    = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

endpackage

// File: rtl/booth_result_fifo.sv
// Small power-of-two FIFO holding committed products; accepts a push when full if a pop happens in the same cycle.
module booth_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_q, rd_q;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop)
                rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/booth_result_collector.sv
// Collects lo/hi product halves from the Booth result bus, commits {hi,lo} on finished into a FIFO.
// Optional watchdog abort of a stalled sequence: define BOOTH_COLLECT_TIMEOUT_EN.
module booth_result_collector
    import booth_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 upload_selector,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       finished,
    output logic                       prod_valid,
    output logic [2*WIDTH-1:0]         prod_data,
    input  logic                       prod_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       seq_err,
    output logic                       ovf_err,
`ifdef BOOTH_COLLECT_TIMEOUT_EN
    output logic                       timeout_err,
`endif
    input  logic                       clr_err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("booth_result_collector: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("booth_result_collector: TIMEOUT must be >= 1");
    end

    collect_state_t   state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             seq_err_q, ovf_err_q;
    logic             seq_set, commit, ovf_set;
    logic             fifo_full, fifo_empty, pop;

    assign pop     = !fifo_empty && prod_ready;
    assign ovf_set = commit && fifo_full && !pop;

`ifdef BOOTH_COLLECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_q, wd_d;
    logic          timeout_err_q, tmo_fire;
`endif

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        seq_set = 1'b0;
        commit  = 1'b0;
        unique case (upload_selector)
            SEL_X: begin
                lo_d    = data_in;
                seq_set = (state_q == HI_HELD);
                state_d = LO_HELD;
            end
            SEL_A: begin
                if (state_q == IDLE) begin
                    seq_set = 1'b1;
                end else begin
                    hi_d    = data_in;
                    state_d = HI_HELD;
                end
            end
            default: ;
        endcase
        // Finished is judged after the selector: only a cycle that starts and stays in HI_HELD commits.
        if (finished) begin
            if (state_q == HI_HELD && state_d == HI_HELD)
                commit = 1'b1;
            else
                seq_set = 1'b1;
            state_d = IDLE;
        end
`ifdef BOOTH_COLLECT_TIMEOUT_EN
        tmo_fire = 1'b0;
        wd_d     = '0;
        if (state_d != IDLE) begin
            if (state_d == state_q && upload_selector != SEL_X && upload_selector != SEL_A) begin
                if (wd_q == TW'(TIMEOUT - 1)) begin
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            seq_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            seq_err_q <= (seq_err_q && !clr_err) || seq_set;
            ovf_err_q <= (ovf_err_q && !clr_err) || ovf_set;
        end
    end

`ifdef BOOTH_COLLECT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= (timeout_err_q && !clr_err) || tmo_fire;
        end
    end
    assign timeout_err = timeout_err_q;
`endif

    booth_result_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (commit),
        .push_data_i ({hi_d, lo_d}),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (prod_data),
        .count_o     (count)
    );

    assign prod_valid = !fifo_empty;
    assign seq_err    = seq_err_q;
    assign ovf_err    = ovf_err_q;

endmodule

// File: doc/booth_result_collector.md
Name: booth_result_collector

Overview:
- Downstream stage of the Booth multiplier controller/datapath.
- Captures the two product halves driven on the shared result bus: the low half (X register) on upload_selector=01, then the high half (A register) on upload_selector=10.
- Assembles the 2*WIDTH-bit product and commits it on `finished`.
- Buffers committed products in a small FIFO and presents them to the consumer over a valid/ready handshake, with sticky sequencing and overflow error flags.

Parameters:
- WIDTH, 8, operand width in bits; the result bus is WIDTH bits and the product is 2*WIDTH bits.
- DEPTH, 2, product FIFO depth; must be a power of two, 2 or greater.
- TIMEOUT, 16, watchdog limit in cycles; used only with BOOTH_COLLECT_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous active-high reset.
- upload_selector  in  2  bus tag: 00 none, 01 low half (X), 10 high half (A), 11 reserved.
- data_in  in  WIDTH  result bus, sampled when upload_selector is non-zero.
- finished  in  1  one-cycle pulse from the controller; commits the assembled product.
- prod_valid  out  1  FIFO non-empty.
- prod_data  out  2*WIDTH  FIFO head, {hi,lo}.
- prod_ready  in  1  consumer accepts the head.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- seq_err  out  1  sticky protocol-violation flag.
- ovf_err  out  1  sticky flag: product dropped because the FIFO was full.
- clr_err  in  1  clears seq_err, ovf_err and timeout_err.

Behaviour:
- Single clock; reset is synchronous, active-high, on port rst.
- Reset:
  - state=IDLE, FIFO empty, prod_valid=0, count=0, prod_data=0.
  - lo/hi holding registers = 0; all error flags = 0.
  - Reset mid-sequence discards the partial product; FIFO contents are lost.
- FSM states: IDLE, LO_HELD, HI_HELD.
  - IDLE:
    - sel=01: lo<=data_in, go to LO_HELD.
    - sel=10: set seq_err, stay in IDLE.
    - finished=1: set seq_err, stay in IDLE.
  - LO_HELD:
    - sel=10: hi<=data_in, go to HI_HELD.
    - sel=01: lo overwritten, stay in LO_HELD (restart, no error).
    - finished=1: set seq_err, go to IDLE.
  - HI_HELD:
    - finished=1: push {hi,lo}, go to IDLE.
    - sel=01: set seq_err, lo<=data_in, go to LO_HELD.
    - sel=10: hi overwritten, no error.
  - sel=11 is ignored in every state; no state change, no error.
  - A non-zero sel and finished in the same cycle: sel is processed first and finished is then evaluated against the new state.
    - Only HI_HELD with sel=10 plus finished commits, using the new hi.
    - All other combinations are treated as early finish: seq_err set, go to IDLE.
- FIFO:
  - Push occurs on the finished edge; prod_valid rises in the cycle after the finished pulse (1-cycle latency).
  - Pop when prod_valid && prod_ready.
  - Full and pop in the same cycle as a push: the push is accepted and count is unchanged.
  - Full with no pop: the product is dropped, ovf_err is set, and FIFO contents are unchanged.
  - Empty with prod_ready=1: no effect.
  - Read and write pointers wrap modulo DEPTH.
  - prod_data holds the head value and stays stable while prod_valid=1 and prod_ready=0.
- Errors:
  - Flags are sticky until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the flag is set (set wins).
- No arithmetic is performed on the product; concatenation is unsigned, {hi,lo}.

Optional Feature:
- BOOTH_COLLECT_TIMEOUT_EN defined:
  - Adds a watchdog counter that resets on entry to LO_HELD or HI_HELD and on every accepted sel.
  - If the FSM stays in LO_HELD or HI_HELD for TIMEOUT consecutive cycles, it aborts to IDLE, discards the partial product and sets output timeout_err (sticky, cleared by clr_err).
- Not defined: no counter, no timeout_err port; the FSM may wait indefinitely.

Decomposition:
- Shared package booth_pkg:
  - state enum collect_state_t {IDLE, LO_HELD, HI_HELD}.
  - Selector constants SEL_NONE=2'b00, SEL_X=2'b01, SEL_A=2'b10, SEL_RSVD=2'b11.
- One sub-module: booth_result_fifo, parameterised by WIDTH and DEPTH. It provides push/pop, the full/empty flags and count.

Test Plan:
- Basic commit:
  - Stimulus: WIDTH=8; sel=01 with data 0x34, then sel=10 with 0x12, then finished.
  - Required: the next cycle has prod_valid=1, prod_data=0x1234, count=1. With prod_ready=1, the following cycle has prod_valid=0.
- Backpressure and overflow:
  - Stimulus: DEPTH=2, prod_ready=0; commit 0x0102, 0x0304, then 0x0506.
  - Required: count=2, ovf_err=1. Draining yields 0x0102 then 0x0304; 0x0506 never appears.
- Full with push and pop in the same cycle:
  - Stimulus: FIFO full; prod_ready=1 in the same cycle as finished for 0xAABB.
  - Required: count stays 2 and 0xAABB is the last product out.
- Protocol errors:
  - Stimulus: sel=10 in IDLE.
  - Required: seq_err=1 and no state change.
  - Stimulus: clr_err, then finished while in LO_HELD.
  - Required: seq_err=1, state returns to IDLE, count unchanged.
- Reset mid-sequence:
  - Stimulus: sel=01 with 0x55, then rst for 1 cycle, then sel=10 with 0x66, then finished.
  - Required: seq_err=1 and no product pushed.
- Timeout (macro defined, TIMEOUT=16):
  - Stimulus: sel=01, then idle for 16 cycles.
  - Required: timeout_err=1, state IDLE. A following sel=10 sets seq_err.
